// File: rtl/result_acc.sv
// Frame accumulator: sums and maxes FRAME_LEN accepted values, then queues
// each completed frame result in a small FIFO with a ready/valid output.
module result_acc #(
    parameter int FRAME_LEN  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [26:0] in_value,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [28:0] out_sum,
    output logic [26:0] out_max,
    output logic        drop_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0]    LAST_IDX = 3'(FRAME_LEN - 1);
    localparam logic [PW-1:0] PTR_MAX  = PW'(FIFO_DEPTH - 1);
    localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACC} state_t;

    state_t        state_q, state_d;
    logic [2:0]    count_q, count_d;
    logic [28:0]   sum_q, sum_d;
    logic [26:0]   max_q, max_d;
    logic [28:0]   acc_sum;
    logic [26:0]   acc_max;
    logic          frame_done;

    logic [28:0]   fsum_q [FIFO_DEPTH];
    logic [28:0]   fsum_d [FIFO_DEPTH];
    logic [26:0]   fmax_q [FIFO_DEPTH];
    logic [26:0]   fmax_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          drop_q, drop_d;
    logic          push, pop, full;

    // Accumulator and frame FSM
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sum_d      = sum_q;
        max_d      = max_q;
        frame_done = 1'b0;
        acc_sum    = sum_q + {2'b00, in_value};
        acc_max    = (count_q == 3'd0 || in_value > max_q) ? in_value : max_q;
        if (in_valid) begin
            if (count_q == LAST_IDX) begin
                frame_done = 1'b1;
                state_d    = IDLE;
                count_d    = '0;
                sum_d      = '0;
                max_d      = '0;
            end else begin
                state_d    = ACC;
                count_d    = count_q + 3'd1;
                sum_d      = acc_sum;
                max_d      = acc_max;
            end
        end
    end

    // FIFO: a push into a full FIFO survives only if the head pops on the same edge
    always_comb begin
        fsum_d   = fsum_q;
        fmax_d   = fmax_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        full     = (occ_q == OCC_FULL);
        pop      = (occ_q != '0) && out_ready;
        push     = frame_done && (!full || pop);
        drop_d   = drop_q | (frame_done && full && !pop);
        if (push) begin
            fsum_d[wr_ptr_q] = acc_sum;
            fmax_d[wr_ptr_q] = acc_max;
            wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            sum_q    <= '0;
            max_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            drop_q   <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fsum_q[i] <= '0;
                fmax_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            max_q    <= max_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            drop_q   <= drop_d;
            fsum_q   <= fsum_d;
            fmax_q   <= fmax_d;
        end
    end

    assign out_valid = (occ_q != '0);
    assign out_sum   = out_valid ? fsum_q[rd_ptr_q] : '0;
    assign out_max   = out_valid ? fmax_q[rd_ptr_q] : '0;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_result_acc.sv
// Scoreboard bench for result_acc: the stimulus queues expected frames,
// and a negedge monitor checks every handshake and the idle-zero outputs.
module tb_result_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [26:0] in_value;
    logic        out_ready;
    logic        out_valid;
    logic [28:0] out_sum;
    logic [26:0] out_max;
    logic        drop_err;

    typedef struct {
        logic [28:0] s;
        logic [26:0] m;
    } frame_t;

    frame_t sb[$];
    int     tests = 0;
    int     fails = 0;

    result_acc #(.FRAME_LEN(4), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_value  (in_value),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_max   (out_max),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input logic [28:0] s, input logic [26:0] m);
        frame_t f;
        f.s = s;
        f.m = m;
        sb.push_back(f);
    endtask

    // Called at #1 after a rising edge; leaves us at #1 after the next one.
    task automatic send(input logic [26:0] v);
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    // Monitor: pops on every handshake, demands zeros whenever nothing is valid
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got sum 0x%0h max 0x%0h, expected none", out_sum, out_max);
                end else begin
                    frame_t e;
                    e = sb.pop_front();
                    check("frame_sum", 64'(out_sum), 64'(e.s));
                    check("frame_max", 64'(out_max), 64'(e.m));
                end
            end else if (!out_valid) begin
                check("idle_outputs_zero", {8'h0, out_sum, out_max}, 64'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b1;
        #1;
        check("reset_outputs", {6'h0, out_valid, drop_err, out_sum, out_max}, 64'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Basic frame 5,9,2,7 with one-cycle latency
        expect_frame(29'd23, 27'd9);
        send(27'd5); send(27'd9); send(27'd2); send(27'd7);
        check("basic_latency_valid", 64'(out_valid), 64'd1);
        check("basic_latency_sum", 64'(out_sum), 64'd23);
        idle(1);
        check("basic_single_cycle", 64'(out_valid), 64'd0);

        // Gaps inside a frame
        expect_frame(29'd10, 27'd4);
        send(27'd1); idle(3);
        send(27'd2); idle(3);
        send(27'd3); idle(3);
        check("gap_no_early_frame", 64'(out_valid), 64'd0);
        send(27'd4);
        check("gap_latency_valid", 64'(out_valid), 64'd1);
        idle(1);

        // Width extremes
        expect_frame(29'h1FFFFFFC, 27'h7FFFFFF);
        repeat (4) send(27'h7FFFFFF);
        idle(1);

        // Backpressure: third frame dropped
        out_ready = 1'b0;
        expect_frame(29'd10, 27'd4);
        send(27'd1); send(27'd2); send(27'd3); send(27'd4);
        expect_frame(29'd20, 27'd8);
        send(27'd2); send(27'd4); send(27'd6); send(27'd8);
        check("no_drop_before_full", 64'(drop_err), 64'd0);
        send(27'd3); send(27'd6); send(27'd9); send(27'd12);
        check("drop_err_set", 64'(drop_err), 64'd1);
        check("stall_head_sum", 64'(out_sum), 64'd10);
        idle(3);
        check("stall_hold_sum", 64'(out_sum), 64'd10);
        check("stall_hold_max", 64'(out_max), 64'd4);
        out_ready = 1'b1;
        idle(1);
        check("drain_second_valid", 64'(out_valid), 64'd1);
        check("drain_second_sum", 64'(out_sum), 64'd20);
        idle(1);
        check("drain_empty", 64'(out_valid), 64'd0);
        check("drop_err_sticky", 64'(drop_err), 64'd1);

        // Reset mid-frame with one frame buffered
        out_ready = 1'b0;
        send(27'd1); send(27'd2); send(27'd3); send(27'd4);
        send(27'd7); send(27'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {6'h0, out_valid, drop_err, out_sum, out_max}, 64'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_frame(29'd4, 27'd1);
        send(27'd1); send(27'd1); send(27'd1); send(27'd1);
        idle(1);

        // Full FIFO with push and pop on the same edge
        out_ready = 1'b0;
        expect_frame(29'd10, 27'd4);
        send(27'd1); send(27'd2); send(27'd3); send(27'd4);
        expect_frame(29'd20, 27'd8);
        send(27'd2); send(27'd4); send(27'd6); send(27'd8);
        expect_frame(29'd40, 27'd10);
        send(27'd10); send(27'd10); send(27'd10);
        out_ready = 1'b1;
        send(27'd10);
        check("simul_no_drop", 64'(drop_err), 64'd0);
        check("simul_head_sum", 64'(out_sum), 64'd20);

        for (int n = 0; n < 20 && sb.size() != 0; n++) idle(1);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        idle(1);
        check("final_empty", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
